// File: rtl/osc_frame_reader.sv
// osc_frame_reader: streams one captured oscilloscope frame per arm request.
//
// Once armed, the block waits for the falling edge of the capture-busy flag,
// then emits the header byte 8'hA5, a flag byte {7'b0, trig_flag}, and DEPTH
// samples read from the capture buffer (read latency 1, 2-entry skid FIFO).
//
// Build option: define OSC_FRAME_CKSUM_EN to append a modulo-256 checksum of
// the sample bytes as a final byte.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   arm        one-cycle request to send the next captured frame (IDLE only)
//   busy       capture-in-progress from the trigger/sampler stage
//   trig_flag  1 = triggered capture, 0 = timeout; latched on busy fall
//   din        signed sample from the capture buffer, valid the cycle after read
//   read       read strobe to the capture buffer
//   m_data     stream byte
//   m_valid    stream byte valid
//   m_ready    downstream accepts the byte
//   active     high from arm acceptance until the last byte transfers
//   done       one-cycle pulse on the last byte transfer
module osc_frame_reader #(
  parameter int unsigned DEPTH = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              busy,
  input  logic              trig_flag,
  input  logic signed [7:0] din,
  output logic              read,
  output logic [7:0]        m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              active,
  output logic              done
);

  localparam logic [9:0] DEPTH_C = 10'(DEPTH);
  localparam logic [9:0] LAST_C  = 10'(DEPTH - 1);

`ifdef OSC_FRAME_CKSUM_EN
  typedef enum logic [2:0] {IDLE, WAIT, HDR, FLAG, DATA, CKSUM} state_e;
`else
  typedef enum logic [2:0] {IDLE, WAIT, HDR, FLAG, DATA} state_e;
`endif

  state_e     state_q, state_d;
  logic       busy_q;
  logic       flag_q, flag_d;
  logic [9:0] rd_cnt_q, rd_cnt_d;
  logic [9:0] tx_cnt_q, tx_cnt_d;
  logic       infl_q;
  logic [7:0] fifo_mem_q [2];
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] count_q;

  logic       fifo_valid;
  logic [7:0] fifo_head;
  logic       push, pop;
  logic [1:0] occ_eff;

  assign fifo_valid = (count_q != 2'd0);
  assign fifo_head  = fifo_mem_q[rd_ptr_q];
  assign push       = infl_q;
  assign pop        = (state_q == DATA) && fifo_valid && m_ready;

  // The entry leaving this cycle is not counted, so a read can be issued
  // alongside a pop; this keeps one sample per cycle with only two entries
  // while occupancy plus reads in flight never exceeds two.
  assign occ_eff = count_q - {1'b0, pop};
  assign read    = (state_q == DATA) && ((occ_eff + {1'b0, infl_q}) < 2'd2)
                   && (rd_cnt_q < DEPTH_C);

  assign active = (state_q != IDLE);

`ifdef OSC_FRAME_CKSUM_EN
  logic [7:0] cksum_q, cksum_d;

  always_comb begin
    cksum_d = cksum_q;
    if (state_q == HDR) begin
      cksum_d = '0;
    end else if (pop) begin
      cksum_d = cksum_q + fifo_head;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cksum_q <= '0;
    end else begin
      cksum_q <= cksum_d;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    flag_d   = flag_q;
    rd_cnt_d = rd_cnt_q;
    tx_cnt_d = tx_cnt_q;
    m_data   = '0;
    m_valid  = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm) state_d = WAIT;
      end
      WAIT: begin
        if (busy_q && !busy) begin
          flag_d  = trig_flag;
          state_d = HDR;
        end
      end
      HDR: begin
        m_data   = 8'hA5;
        m_valid  = 1'b1;
        rd_cnt_d = '0;
        tx_cnt_d = '0;
        if (m_ready) state_d = FLAG;
      end
      FLAG: begin
        m_data  = {7'b0, flag_q};
        m_valid = 1'b1;
        if (m_ready) state_d = DATA;
      end
      DATA: begin
        m_data  = fifo_head;
        m_valid = fifo_valid;
        if (read) rd_cnt_d = rd_cnt_q + 10'd1;
        if (pop) begin
          tx_cnt_d = tx_cnt_q + 10'd1;
          if (tx_cnt_q == LAST_C) begin
`ifdef OSC_FRAME_CKSUM_EN
            state_d = CKSUM;
`else
            state_d = IDLE;
            done    = 1'b1;
`endif
          end
        end
      end
`ifdef OSC_FRAME_CKSUM_EN
      CKSUM: begin
        m_data  = cksum_q;
        m_valid = 1'b1;
        if (m_ready) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      flag_q        <= 1'b0;
      rd_cnt_q      <= '0;
      tx_cnt_q      <= '0;
      infl_q        <= 1'b0;
      fifo_mem_q[0] <= '0;
      fifo_mem_q[1] <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy;
      flag_q   <= flag_d;
      rd_cnt_q <= rd_cnt_d;
      tx_cnt_q <= tx_cnt_d;
      infl_q   <= read;
      if (state_q == HDR) begin
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
        count_q  <= '0;
      end else begin
        if (push) begin
          fifo_mem_q[wr_ptr_q] <= $unsigned(din);
          wr_ptr_q             <= ~wr_ptr_q;
        end
        if (pop) rd_ptr_q <= ~rd_ptr_q;
        count_q <= count_q + {1'b0, push} - {1'b0, pop};
      end
    end
  end

endmodule

// File: tb/tb_osc_frame_reader.sv
// Bench for osc_frame_reader: instance 0 uses DEPTH=1000, instance 1 DEPTH=4.
// A buffer model answers read strobes one cycle later; a monitor records
// every transferred byte, read strobe, done pulse and any stall violation.
`timescale 1ns/1ps
module tb_osc_frame_reader;

  localparam int unsigned D0 = 1000;
  localparam int unsigned D1 = 4;
`ifdef OSC_FRAME_CKSUM_EN
  localparam int unsigned CK = 1;
`else
  localparam int unsigned CK = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic              arm      [2];
  logic              busy     [2];
  logic              trig     [2];
  logic              rdy      [2];
  logic signed [7:0] din      [2];
  logic              read     [2];
  logic [7:0]        m_data   [2];
  logic              m_valid  [2];
  logic              active   [2];
  logic              done     [2];

  osc_frame_reader #(.DEPTH(D0)) u_dut0 (
    .clk(clk), .rst(rst), .arm(arm[0]), .busy(busy[0]), .trig_flag(trig[0]),
    .din(din[0]), .read(read[0]), .m_data(m_data[0]), .m_valid(m_valid[0]),
    .m_ready(rdy[0]), .active(active[0]), .done(done[0])
  );

  osc_frame_reader #(.DEPTH(D1)) u_dut1 (
    .clk(clk), .rst(rst), .arm(arm[1]), .busy(busy[1]), .trig_flag(trig[1]),
    .din(din[1]), .read(read[1]), .m_data(m_data[1]), .m_valid(m_valid[1]),
    .m_ready(rdy[1]), .active(active[1]), .done(done[1])
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Buffer contents: instance 0 a ramp, instance 1 the hand vector 7F,01,80,FF.
  function automatic logic [7:0] sample(input int g, input int unsigned k);
    logic [7:0] t1 [4];
    t1 = '{8'h7F, 8'h01, 8'h80, 8'hFF};
    if (g == 0) return 8'((k * 7 + 3) % 256);
    return t1[k % 4];
  endfunction

  int unsigned rdy_mode [2];
  int unsigned cyc;
  int unsigned rdcnt [2];
  int unsigned rdbase [2];
  int unsigned rxn [2];
  int unsigned rxbase [2];
  int unsigned donecnt [2];
  int unsigned donecyc [2];
  int unsigned stall_err [2];
  logic [7:0]  rxbuf [2][4096];
  int unsigned rxcyc [2][4096];
  logic [7:0]  din_next [2];
  logic        pv [2];
  logic        pr [2];
  logic [7:0]  pd [2];

  // Ready driver: always ready, or ready 30% of cycles.
  initial begin
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++)
        rdy[g] = (rdy_mode[g] == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
    end
  end

  // Monitor samples just before each rising edge, after inputs settle.
  always @(negedge clk) begin
    #3;
    cyc++;
    for (int g = 0; g < 2; g++) begin
      din_next[g] = 8'hEE;
      if (read[g]) begin
        din_next[g] = sample(g, rdcnt[g] - rdbase[g]);
        rdcnt[g]++;
      end
      if (m_valid[g] && rdy[g]) begin
        rxbuf[g][rxn[g] % 4096] = m_data[g];
        rxcyc[g][rxn[g] % 4096] = cyc;
        rxn[g]++;
      end
      if (done[g]) begin
        donecnt[g]++;
        donecyc[g] = cyc;
      end
      if (rst && pv[g] && !pr[g] && (!m_valid[g] || m_data[g] != pd[g]))
        stall_err[g]++;
      pv[g] = rst & m_valid[g];
      pr[g] = rdy[g];
      pd[g] = m_data[g];
    end
  end

  // Buffer read data appears the cycle after the strobe.
  always @(posedge clk) begin
    #1;
    din[0] = din_next[0];
    din[1] = din_next[1];
  end

  task automatic run_frame(input int g, input logic flag, input int unsigned mode,
                           input bit toggle, input bit arm2, input bit pre_low,
                           input string tag);
    int unsigned dep;
    int unsigned fl;
    int unsigned d0;
    int unsigned bad;
    int unsigned sum;
    int unsigned guard;
    int unsigned last;
    dep = (g == 0) ? D0 : D1;
    fl  = dep + 2 + CK;
    d0  = donecnt[g];
    rdbase[g]   = rdcnt[g];
    rxbase[g]   = rxn[g];
    rdy_mode[g] = mode;
    busy[g] = 1'b0;
    @(negedge clk) arm[g] = 1'b1;
    @(negedge clk) arm[g] = 1'b0;
    if (pre_low) begin
      bad = 0;
      repeat (20) begin
        @(negedge clk);
        if (m_valid[g] || !active[g]) bad++;
      end
      check({tag, " wait_hold"}, bad, 0);
      check({tag, " wait_nobytes"}, rxn[g] - rxbase[g], 0);
      busy[g] = 1'b1;
      repeat (5) @(negedge clk);
    end else begin
      busy[g] = 1'b1;
      repeat (50) @(negedge clk);
    end
    trig[g] = flag;
    busy[g] = 1'b0;
    @(negedge clk) trig[g] = ~flag;
    guard = 0;
    while (donecnt[g] == d0 && guard < 20000) begin
      @(negedge clk);
      guard++;
      if (toggle) busy[g] = 1'($urandom_range(0, 1));
      arm[g] = (arm2 && guard == 100);
    end
    busy[g] = 1'b0;
    arm[g]  = 1'b0;
    check({tag, " no_timeout"}, guard < 20000, 1);
    repeat (10) @(negedge clk);
    check({tag, " length"}, rxn[g] - rxbase[g], fl);
    check({tag, " hdr"}, rxbuf[g][rxbase[g] % 4096], 8'hA5);
    check({tag, " flag"}, rxbuf[g][(rxbase[g] + 1) % 4096], {7'b0, flag});
    bad = 0;
    sum = 0;
    for (int unsigned k = 0; k < dep; k++) begin
      sum = (sum + sample(g, k)) % 256;
      if (rxbuf[g][(rxbase[g] + 2 + k) % 4096] !== sample(g, k)) bad++;
    end
    check({tag, " samples_bad"}, bad, 0);
`ifdef OSC_FRAME_CKSUM_EN
    check({tag, " cksum"}, rxbuf[g][(rxbase[g] + 2 + dep) % 4096], sum);
`endif
    check({tag, " reads"}, rdcnt[g] - rdbase[g], dep);
    check({tag, " done_count"}, donecnt[g] - d0, 1);
    last = (rxbase[g] + fl - 1) % 4096;
    check({tag, " done_on_last"}, donecyc[g], rxcyc[g][last]);
    check({tag, " stall_err"}, stall_err[g], 0);
    check({tag, " idle_after"}, active[g], 0);
    if (mode == 0)
      check({tag, " burst"},
            rxcyc[g][(rxbase[g] + 1 + dep) % 4096] - rxcyc[g][(rxbase[g] + 2) % 4096],
            dep - 1);
  endtask

  int unsigned guard_r;
  int unsigned n0;

  initial begin
    for (int g = 0; g < 2; g++) begin
      arm[g] = 1'b0; busy[g] = 1'b0; trig[g] = 1'b0; din[g] = '0;
      rdy_mode[g] = 0;
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check("reset read", read[g], 0);
      check("reset m_valid", m_valid[g], 0);
      check("reset m_data", m_data[g], 0);
      check("reset active", active[g], 0);
      check("reset done", done[g], 0);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(0, 1'b1, 0, 1'b0, 1'b0, 1'b0, "d1000_ready");
    run_frame(0, 1'b1, 1, 1'b0, 1'b0, 1'b0, "d1000_stall");
    run_frame(0, 1'b0, 0, 1'b1, 1'b1, 1'b0, "d1000_timeout");

    run_frame(1, 1'b1, 0, 1'b0, 1'b0, 1'b1, "d4_prelow");
    check("d4 byte2", rxbuf[1][(rxbase[1] + 2) % 4096], 8'h7F);
    check("d4 byte3", rxbuf[1][(rxbase[1] + 3) % 4096], 8'h01);
    check("d4 byte4", rxbuf[1][(rxbase[1] + 4) % 4096], 8'h80);
    check("d4 byte5", rxbuf[1][(rxbase[1] + 5) % 4096], 8'hFF);
`ifdef OSC_FRAME_CKSUM_EN
    check("d4 cksum_const", rxbuf[1][(rxbase[1] + 6) % 4096], 8'hFF);
`endif
    run_frame(1, 1'b0, 1, 1'b0, 1'b0, 1'b0, "d4_stall");

    // Reset in the middle of a DEPTH=1000 frame.
    rdbase[0] = rdcnt[0];
    rxbase[0] = rxn[0];
    rdy_mode[0] = 0;
    @(negedge clk) arm[0] = 1'b1;
    @(negedge clk) begin arm[0] = 1'b0; busy[0] = 1'b1; end
    repeat (50) @(negedge clk);
    trig[0] = 1'b1;
    busy[0] = 1'b0;
    guard_r = 0;
    while (rxn[0] - rxbase[0] < 302 && guard_r < 5000) begin
      @(negedge clk);
      guard_r++;
    end
    check("rst reached_300", guard_r < 5000, 1);
    rst = 1'b0;
    #1;
    check("rst read", read[0], 0);
    check("rst m_valid", m_valid[0], 0);
    check("rst m_data", m_data[0], 0);
    check("rst active", active[0], 0);
    check("rst done", done[0], 0);
    @(negedge clk) rst = 1'b1;
    n0 = rxn[0];
    repeat (30) @(negedge clk);
    busy[0] = 1'b1;
    repeat (10) @(negedge clk);
    busy[0] = 1'b0;
    repeat (20) @(negedge clk);
    check("rst nobytes", rxn[0] - n0, 0);
    check("rst stays_idle", active[0], 0);
    run_frame(0, 1'b1, 0, 1'b0, 1'b0, 1'b0, "d1000_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/osc_frame_reader.md
OSC_FRAME_READER -- requirements
Module: osc_frame_reader

Interface
REQ-001 SHALL have parameter DEPTH, default 1000: samples read per frame, range 1..1023.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port arm, input, 1 bit: one-cycle request to send the next captured frame.
REQ-005 SHALL have port busy, input, 1 bit: capture-in-progress from the trigger/sampler stage.
REQ-006 SHALL have port trig_flag, input, 1 bit: high when the capture was triggered, low when it timed out.
REQ-007 SHALL have port din, input, 8 bits signed: sample from the capture buffer.
REQ-008 SHALL have port read, output, 1 bit: read strobe to the capture buffer.
REQ-009 SHALL have port m_data, output, 8 bits: stream byte.
REQ-010 SHALL have port m_valid, output, 1 bit: stream byte valid.
REQ-011 SHALL have port m_ready, input, 1 bit: downstream accepts the byte.
REQ-012 SHALL have port active, output, 1 bit: high from arm acceptance until the last byte transfers.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse on the cycle the last byte transfers.

Function
REQ-014 SHALL implement states IDLE, WAIT, HDR, FLAG, DATA, CKSUM.
REQ-015 SHALL move IDLE->WAIT on arm=1; arm SHALL be ignored in every other state.
REQ-016 SHALL, in WAIT, register busy each cycle and detect a falling edge: registered busy=1 and current busy=0.
REQ-017 SHALL, on that edge, latch trig_flag and go to HDR; a busy that is already low at arm SHALL NOT start a frame.
REQ-018 SHALL, in HDR, present m_data=8'hA5 with m_valid=1, then go to FLAG on transfer (m_valid&&m_ready).
REQ-019 SHALL, in FLAG, present {7'b0, latched trig_flag}, then go to DATA on transfer.
REQ-020 SHALL define buffer read latency as 1: din is valid on the cycle after read=1.
REQ-021 SHALL, in DATA, buffer samples in a 2-entry FIFO.
REQ-022 SHALL assert read only when FIFO occupancy + reads in flight < 2 and fewer than DEPTH reads have been issued.
REQ-023 SHALL issue exactly DEPTH reads per frame, including under arbitrary m_ready stalls.
REQ-024 SHALL sustain one sample per cycle in DATA when m_ready is held high.
REQ-025 SHALL output samples in read order, unmodified.
REQ-026 SHALL hold m_data and m_valid stable while m_valid=1 and m_ready=0.
REQ-027 SHALL never drop m_valid without a transfer.
REQ-028 SHALL leave DATA after the DEPTH-th sample transfers, going to CKSUM or IDLE according to REQ-035/REQ-036.
REQ-029 SHALL keep the checksum as an 8-bit modulo-256 sum of transferred sample bytes, cleared in HDR.
REQ-030 SHALL keep the read counter 10 bits wide and clear it in HDR.
REQ-031 SHALL drive m_valid=0 in IDLE and WAIT, and read=0 outside DATA.
REQ-032 SHALL ignore busy changes in any state after WAIT.

Reset
REQ-033 SHALL, on rst=0 at any time, including mid-frame, immediately force: state=IDLE, read=0, m_valid=0, m_data=8'h00, active=0, done=0, FIFO empty, counters and checksum 0.
REQ-034 SHALL, after reset deasserts, begin no frame without a new arm; a partial frame is abandoned, not resumed.

Configuration
REQ-035 SHALL, when macro OSC_FRAME_CKSUM_EN is defined, go DATA->CKSUM and send the checksum byte as the final byte; done pulses on its transfer; frame length = DEPTH+3.
REQ-036 SHALL, when OSC_FRAME_CKSUM_EN is undefined, omit the CKSUM state and checksum logic, go DATA->IDLE, and pulse done on the last sample transfer; frame length = DEPTH+2.

Verification
REQ-037 SHALL cover: DEPTH=1000, macro on, m_ready=1, arm, then busy high 50 cycles and low, trig_flag=1 -> bytes A5,01, 1000 samples equal to buffer contents, correct sum; exactly 1000 read pulses; done once.
REQ-038 SHALL cover: same stimulus with m_ready random at 30% -> identical byte sequence; no m_data change while stalled; still 1000 reads.
REQ-039 SHALL cover: trig_flag=0 at busy fall (timeout) -> second byte 8'h00; busy toggling during DATA -> no effect on the frame.
REQ-040 SHALL cover: arm with busy already low for 20 cycles -> stays in WAIT, m_valid=0, until the next busy fall; a second arm during DATA -> ignored.
REQ-041 SHALL cover: rst pulsed low after 300 samples -> all outputs 0 within the same cycle; no bytes after rst rises until a fresh arm plus busy fall, then a full frame.
REQ-042 SHALL cover: macro off, DEPTH=4, samples 7F,01,80,FF -> bytes A5,01,7F,01,80,FF with done on FF; with macro on the frame ends with checksum 8'hFF.
